// File: rtl/result_chk_pkg.sv
// Shared types and constants for the result_checker monitor: FSM states,
// error codes, traffic-light encodings and the dice successor function.
package result_chk_pkg;

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_DICE   = 2'd1,
    ST_LIGHTS = 2'd2
  } state_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISMATCH = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;

  // Lights encoding is {red, amb, gre}.
  localparam logic [2:0] L_RED    = 3'b100;
  localparam logic [2:0] L_REDAMB = 3'b110;
  localparam logic [2:0] L_GRE    = 3'b001;
  localparam logic [2:0] L_AMB    = 3'b010;

  // Next dice face: 0/7 recover to 1, a roll advances 1..6 cyclically.
  function automatic logic [2:0] dice_next(input logic [2:0] prev, input logic rolled);
    logic [2:0] nxt;
    if ((prev == 3'd0) || (prev == 3'd7)) begin
      nxt = 3'd1;
    end else if (rolled) begin
      nxt = (prev == 3'd6) ? 3'd1 : prev + 3'd1;
    end else begin
      nxt = prev;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/result_predictor.sv
// Combinational prediction of the legal next result value from the previous
// observed value; flags previous lights codes outside the four-step cycle.
module result_predictor
  import result_chk_pkg::*;
(
  input  logic [2:0] prev_i,
  input  logic       prev_button_i,
  input  logic       mode_i,
  output logic [2:0] expected_o,
  output logic       illegal_o
);

  always_comb begin
    expected_o = 3'd0;
    illegal_o  = 1'b0;
    if (mode_i) begin
      case (prev_i)
        L_RED:    expected_o = L_REDAMB;
        L_REDAMB: expected_o = L_GRE;
        L_GRE:    expected_o = L_AMB;
        L_AMB:    expected_o = L_RED;
        default: begin
          expected_o = L_RED;
          illegal_o  = 1'b1;
        end
      endcase
    end else begin
      expected_o = dice_next(prev_i, prev_button_i);
    end
  end

endmodule

// File: rtl/result_checker.sv
// Passive monitor of the dice/traffic-lights result bus: tracks mode, predicts
// each value, and reports sticky error, saturating count, last code and lock.
module result_checker
  import result_chk_pkg::*;
#(
  parameter int ERR_CNT_W = 8,
  parameter int LOCK_LEN  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sel,
  input  logic                 button,
  input  logic [2:0]           result,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [1:0]           err_code,
  output logic                 locked
);

  localparam logic [3:0]           LOCK_MAX = 4'(LOCK_LEN);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX  = {ERR_CNT_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] CNT_ONE  = ERR_CNT_W'(1);

  state_e               state_q, state_d;
  logic [2:0]           prev_q;
  logic                 prev_button_q;
  logic [3:0]           good_q, good_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [1:0]           err_code_q, err_code_d;
  logic                 locked_q, locked_d;

  logic [2:0]           expected_s;
  logic                 illegal_s;
  logic                 check_s;
  logic                 err_ev_s;

  result_predictor u_predictor (
    .prev_i        (prev_q),
    .prev_button_i (prev_button_q),
    .mode_i        (state_q == ST_LIGHTS),
    .expected_o    (expected_s),
    .illegal_o     (illegal_s)
  );

  // A sel change leaves the check disabled for that cycle, so no error can fire.
  always_comb begin
    state_d    = state_q;
    check_s    = 1'b0;
    err_ev_s   = 1'b0;
    err_code_d = err_code_q;
    case (state_q)
      ST_SYNC:   state_d = sel ? ST_LIGHTS : ST_DICE;
      ST_DICE:   if (sel)  state_d = ST_SYNC; else check_s = 1'b1;
      ST_LIGHTS: if (!sel) state_d = ST_SYNC; else check_s = 1'b1;
      default:   state_d = ST_SYNC;
    endcase

    if (check_s) begin
      if (illegal_s) begin
        err_ev_s   = 1'b1;
        err_code_d = ERR_ILLEGAL;
        state_d    = ST_SYNC;
      end else if (result != expected_s) begin
        err_ev_s   = 1'b1;
        err_code_d = ERR_MISMATCH;
      end else begin
        err_ev_s   = 1'b0;
      end
    end else begin
      err_ev_s = 1'b0;
    end
  end

  always_comb begin
    err_d     = err_q | err_ev_s;
    err_cnt_d = err_cnt_q;
    if (err_ev_s && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + CNT_ONE;
    end else begin
      err_cnt_d = err_cnt_q;
    end

    if (!check_s || err_ev_s) begin
      good_d = 4'd0;
    end else if (good_q < LOCK_MAX) begin
      good_d = good_q + 4'd1;
    end else begin
      good_d = good_q;
    end
    locked_d = check_s && !err_ev_s && (good_d == LOCK_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_SYNC;
      prev_q        <= 3'd0;
      prev_button_q <= 1'b0;
      good_q        <= 4'd0;
      err_q         <= 1'b0;
      err_cnt_q     <= '0;
      err_code_q    <= ERR_NONE;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_q        <= result;
      prev_button_q <= button;
      good_q        <= good_d;
      err_q         <= err_d;
      err_cnt_q     <= err_cnt_d;
      err_code_q    <= err_code_d;
      locked_q      <= locked_d;
    end
  end

  assign err      = err_q;
  assign err_cnt  = err_cnt_q;
  assign err_code = err_code_q;
  assign locked   = locked_q;

endmodule

// File: tb/tb_result_checker.sv
// Directed bench for result_checker: dice, lights, mode switch, saturation
// (second instance with a 2-bit counter) and asynchronous reset.
module tb_result_checker;
  import result_chk_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sel = 1'b0;
  logic       button = 1'b0;
  logic [2:0] result = 3'd0;

  logic       err, locked;
  logic [7:0] err_cnt;
  logic [1:0] err_code;
  logic       s_err, s_locked;
  logic [1:0] s_err_cnt;
  logic [1:0] s_err_code;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  result_checker #(.ERR_CNT_W(8), .LOCK_LEN(4)) u_dut (
    .clk(clk), .rst(rst), .sel(sel), .button(button), .result(result),
    .err(err), .err_cnt(err_cnt), .err_code(err_code), .locked(locked)
  );

  result_checker #(.ERR_CNT_W(2), .LOCK_LEN(4)) u_sat (
    .clk(clk), .rst(rst), .sel(sel), .button(button), .result(result),
    .err(s_err), .err_cnt(s_err_cnt), .err_code(s_err_code), .locked(s_locked)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_err, input logic [7:0] e_cnt,
                           input logic [1:0] e_code, input logic e_lock);
    check_eq({tag, ".err"},      32'(err),      32'(e_err));
    check_eq({tag, ".err_cnt"},  32'(err_cnt),  32'(e_cnt));
    check_eq({tag, ".err_code"}, 32'(err_code), 32'(e_code));
    check_eq({tag, ".locked"},   32'(locked),   32'(e_lock));
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic cyc(input logic s, input logic b, input logic [2:0] r);
    sel = s; button = b; result = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all("reset", 1'b0, 8'd0, ERR_NONE, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    // Dice roll with button held
    do_reset();
    cyc(1'b0, 1'b1, 3'd0);
    check_all("dice_sync", 1'b0, 8'd0, ERR_NONE, 1'b0);
    cyc(1'b0, 1'b1, 3'd1);
    cyc(1'b0, 1'b1, 3'd2);
    cyc(1'b0, 1'b1, 3'd3);
    check_eq("dice_3good.locked", 32'(locked), 32'(1'b0));
    cyc(1'b0, 1'b1, 3'd4);
    check_eq("dice_4good.locked", 32'(locked), 32'(1'b1));
    cyc(1'b0, 1'b1, 3'd5);
    cyc(1'b0, 1'b1, 3'd6);
    cyc(1'b0, 1'b1, 3'd1);
    check_all("dice_wrap", 1'b0, 8'd0, ERR_NONE, 1'b1);

    // Dice hold then mismatch
    cyc(1'b0, 1'b1, 3'd2);
    cyc(1'b0, 1'b0, 3'd3);
    cyc(1'b0, 1'b0, 3'd3);
    check_all("dice_hold", 1'b0, 8'd0, ERR_NONE, 1'b1);
    cyc(1'b0, 1'b0, 3'd5);
    check_all("dice_mismatch", 1'b1, 8'd1, ERR_MISMATCH, 1'b0);
    check_eq("sat_first", 32'(s_err_cnt), 32'd1);

    // Lights cycle, then injected illegal code
    do_reset();
    cyc(1'b1, 1'b0, L_RED);
    cyc(1'b1, 1'b0, L_REDAMB);
    cyc(1'b1, 1'b0, L_GRE);
    cyc(1'b1, 1'b0, L_AMB);
    cyc(1'b1, 1'b0, L_RED);
    check_all("lights_cycle", 1'b0, 8'd0, ERR_NONE, 1'b1);
    cyc(1'b1, 1'b0, 3'b111);
    check_all("lights_bad_value", 1'b1, 8'd1, ERR_MISMATCH, 1'b0);
    cyc(1'b1, 1'b0, L_RED);
    check_all("lights_illegal", 1'b1, 8'd2, ERR_ILLEGAL, 1'b0);
    cyc(1'b1, 1'b0, L_RED);
    check_all("lights_resync", 1'b1, 8'd2, ERR_ILLEGAL, 1'b0);
    cyc(1'b1, 1'b0, L_REDAMB);
    check_all("lights_resume_ok", 1'b1, 8'd2, ERR_ILLEGAL, 1'b0);
    cyc(1'b1, 1'b0, L_RED);
    check_all("lights_resume_bad", 1'b1, 8'd3, ERR_MISMATCH, 1'b0);

    // Mode switch from dice to lights mid-sequence
    do_reset();
    cyc(1'b0, 1'b1, 3'd0);
    cyc(1'b0, 1'b1, 3'd1);
    cyc(1'b0, 1'b1, 3'd2);
    cyc(1'b0, 1'b1, 3'd3);
    cyc(1'b0, 1'b1, 3'd4);
    check_all("switch_pre", 1'b0, 8'd0, ERR_NONE, 1'b1);
    cyc(1'b1, 1'b0, L_RED);
    check_eq("switch_edge.err", 32'(err), 32'(1'b0));
    cyc(1'b1, 1'b0, L_REDAMB);
    check_all("switch_sync", 1'b0, 8'd0, ERR_NONE, 1'b0);
    cyc(1'b1, 1'b0, L_GRE);
    check_all("switch_first_check", 1'b0, 8'd0, ERR_NONE, 1'b0);
    cyc(1'b1, 1'b0, L_RED);
    check_all("switch_checking", 1'b1, 8'd1, ERR_MISMATCH, 1'b0);

    // Saturation of the 2-bit counter
    do_reset();
    check_eq("sat_reset", 32'(s_err_cnt), 32'd0);
    cyc(1'b0, 1'b0, 3'd0);
    cyc(1'b0, 1'b0, 3'd2);
    check_eq("sat_1", 32'(s_err_cnt), 32'd1);
    cyc(1'b0, 1'b0, 3'd4);
    check_eq("sat_2", 32'(s_err_cnt), 32'd2);
    cyc(1'b0, 1'b0, 3'd2);
    check_eq("sat_3", 32'(s_err_cnt), 32'd3);
    cyc(1'b0, 1'b0, 3'd4);
    check_eq("sat_hold", 32'(s_err_cnt), 32'd3);
    check_eq("sat_err", 32'(s_err), 32'(1'b1));
    check_eq("sat_main_cnt", 32'(err_cnt), 32'd4);

    // Asynchronous reset between edges
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all("async_rst", 1'b0, 8'd0, ERR_NONE, 1'b0);
    check_eq("async_rst.sat_cnt", 32'(s_err_cnt), 32'd0);
    #1;
    rst = 1'b0;
    cyc(1'b0, 1'b0, 3'd5);
    check_all("post_rst_sync", 1'b0, 8'd0, ERR_NONE, 1'b0);
    cyc(1'b0, 1'b0, 3'd5);
    check_all("post_rst_hold", 1'b0, 8'd0, ERR_NONE, 1'b0);
    cyc(1'b0, 1'b0, 3'd1);
    check_all("post_rst_bad", 1'b1, 8'd1, ERR_MISMATCH, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/result_checker.md
Name: result_checker

Overview:
- Passive receive-side monitor for the 3-bit `result` bus driven by the dice/traffic-lights multiplexer.
- Watches `sel` and `button`, predicts the legal next value each cycle, and compares it with the observed value.
- Flags mismatches and illegal codes, counts errors, and reports lock.
- Sits beside the multiplexer in the bench and in on-board self-check builds; it never drives the DUT.

Parameters:
- ERR_CNT_W, 8, width of the saturating error counter.
- LOCK_LEN, 4, consecutive good checked cycles needed to assert `locked` (1..15).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- sel  input  1  mode select: 0 = dice, 1 = traffic lights.
- button  input  1  dice roll enable, as seen by the dice block.
- result  input  3  observed output bus; lights encoding is {red, amb, gre}.
- err  output  1  sticky error flag.
- err_cnt  output  ERR_CNT_W  number of error events, saturating.
- err_code  output  2  code of the last error: 00 none, 01 mismatch, 10 illegal lights code, 11 reserved.
- locked  output  1  LOCK_LEN consecutive good checks seen.

Behaviour:
- Reset values (asynchronous): err=0, err_cnt=0, err_code=00, locked=0, state=SYNC, prev/prev_button registers=0, good-run counter=0.
- Each clock, register prev <= result and prev_button <= button (one-cycle history).
- State machine:
  - SYNC: no check this cycle. Next state is DICE if sel=0, LIGHTS if sel=1.
  - DICE: check active while sel=0. If sel=1, go to SYNC and skip the check that cycle.
  - LIGHTS: check active while sel=1. If sel=0, go to SYNC and skip the check.
- Dice expected value, from prev and prev_button:
  - prev is 0 or 7: expected 1, regardless of button.
  - prev_button=1: expected prev+1, with 6 wrapping to 1.
  - prev_button=0: expected prev (hold).
- Lights expected sequence, one step per clock: 100 -> 110 -> 001 -> 010 -> 100.
  - If prev is any other code: error event with err_code=10, then go to SYNC.
- Check in DICE/LIGHTS: result != expected gives an error event with err_code=01.
- On every error event:
  - err <= 1 (sticky until rst).
  - err_cnt <= err_cnt+1, holding at 2^ERR_CNT_W-1.
  - err_code updated to the new code.
  - good-run counter cleared; locked <= 0.
- Good check: good-run counter increments, saturating at LOCK_LEN. When the counter equals LOCK_LEN, locked <= 1.
- SYNC clears the good-run counter and locked.
- Latency: flags and count change on the clock edge that samples the offending result. They are visible to the bench one cycle after result is driven.
- Simultaneous events:
  - A sel change takes priority over the check in that cycle; no error is raised.
  - An illegal lights code uses err_code=10 even if it would also mismatch.
- Reset mid-operation: all outputs clear immediately (asynchronously). The first post-reset edge is a SYNC cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package result_chk_pkg holds:
  - state enum {SYNC, DICE, LIGHTS}.
  - err_code constants ERR_NONE, ERR_MISMATCH, ERR_ILLEGAL.
  - light codes L_RED=100, L_REDAMB=110, L_GRE=001, L_AMB=010.
- One sub-module is natural: result_predictor, combinational. It takes prev, prev_button and mode, and returns expected and illegal.
- Counters and the FSM stay in the top module.

Test Plan:
- Dice roll: reset; sel=0; result driven 0,1,2,3,4,5,6,1 with button=1 -> err=0, locked=1 after 4 good checks, err_cnt=0.
- Dice hold and mismatch: button=0 with result 3,3 -> no error; then result 5 -> err=1, err_code=01, err_cnt=1, locked=0.
- Lights cycle: sel=1, result 100,110,001,010,100 -> err=0, locked=1. Then inject 111 -> err_code=10 on the next check, state returns to SYNC.
- Mode switch: toggle sel mid-sequence while result jumps from 4 to 100 -> no error in the switch cycle, one SYNC cycle, checking resumes in LIGHTS.
- Saturation: ERR_CNT_W=2 with continuous mismatches -> err_cnt climbs 1,2,3 and stays at 3.
- Async reset: assert rst between clock edges with err=1 -> all outputs 0 before the next edge; first post-reset cycle does not check.
